// File: rtl/fpga_hero_pkg.sv
// Shared constants and types for the falling-note lane sequencer.
package fpga_hero_pkg;

    localparam int unsigned SCREEN_W     = 640;
    localparam int unsigned PIXELSPEED   = 5;
    localparam int unsigned NOTELENGTH   = 150;
    localparam int unsigned WRAP_POS     = SCREEN_W - 1 + NOTELENGTH;
    localparam int unsigned BEAT_SPACING = 160;
    localparam int unsigned POS_W        = 10;
    localparam int unsigned SCORE_W      = 20;

    typedef enum logic [1:0] {IDLE, SCAN, FETCH, LOAD} sched_state_t;

    typedef logic [3:0] note_line_t;

endpackage

// File: rtl/beat_lane_scheduler.sv
// Once per frame advances every beat slot, recycles slots that scrolled off-screen
// and reloads their note pattern from the song ROM; also keeps the frame score.
module beat_lane_scheduler
    import fpga_hero_pkg::*;
#(
    parameter int unsigned NUM_BEATS   = 4,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned SONG_LEN    = 256,
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic                       vgaclk,
    input  logic                       rst,
    input  logic                       frame_tick,
    input  logic                       pause,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [3:0]                 rom_data,
    output logic [NUM_BEATS*POS_W-1:0] beat_pos,
    output logic [NUM_BEATS*4-1:0]     beat_notes,
    output logic                       busy,
    output logic                       update_done,
    output logic                       overrun,
    output logic                       song_done,
    output logic [SCORE_W-1:0]         score
);

    localparam int unsigned IDX_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int unsigned CNT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_BEATS - 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(SONG_LEN - 1);
    localparam logic [CNT_W-1:0]   WAIT_INIT = CNT_W'(ROM_LATENCY - 1);
    localparam logic [POS_W-1:0]   WRAP      = POS_W'(WRAP_POS);
    localparam logic [POS_W-1:0]   STEP      = POS_W'(PIXELSPEED);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    sched_state_t      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [POS_W-1:0]  pos_q [NUM_BEATS];
    logic [POS_W-1:0]  pos_d [NUM_BEATS];
    note_line_t        notes_q [NUM_BEATS];
    note_line_t        notes_d [NUM_BEATS];
    logic [ADDR_W-1:0] rom_addr_d;
    logic [SCORE_W-1:0] score_d;
    logic              busy_d, done_d, overrun_d, song_done_d;
    logic              slot_done;

    // Next-state and datapath update; one slot is handled per SCAN/LOAD step.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        pos_d       = pos_q;
        notes_d     = notes_q;
        rom_addr_d  = rom_addr;
        score_d     = score;
        busy_d      = busy;
        done_d      = 1'b0;
        overrun_d   = overrun | (frame_tick & (state_q != IDLE));
        song_done_d = song_done;
        slot_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_tick && !pause) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    if (score != SCORE_MAX) begin
                        score_d = score + SCORE_W'(1);
                    end
                end
            end
            SCAN: begin
                if (pos_q[idx_q] >= WRAP) begin
                    pos_d[idx_q] = '0;
                    cnt_d        = WAIT_INIT;
                    state_d      = FETCH;
                end else begin
                    pos_d[idx_q] = pos_q[idx_q] + STEP;
                    slot_done    = 1'b1;
                end
            end
            FETCH: begin
                if (cnt_q == '0) begin
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LOAD: begin
                notes_d[idx_q] = song_done ? 4'b0000 : rom_data;
                if (rom_addr == LAST_ADDR) begin
                    song_done_d = 1'b1;
                end else begin
                    rom_addr_d = rom_addr + ADDR_W'(1);
                end
                slot_done = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (slot_done) begin
            if (idx_q == LAST_IDX) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = SCAN;
            end
        end
    end

    always_ff @(posedge vgaclk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            rom_addr    <= '0;
            score       <= '0;
            busy        <= 1'b0;
            update_done <= 1'b0;
            overrun     <= 1'b0;
            song_done   <= 1'b0;
            for (int unsigned i = 0; i < NUM_BEATS; i++) begin
                pos_q[i]   <= POS_W'(i * BEAT_SPACING);
                notes_q[i] <= 4'b1111;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            rom_addr    <= rom_addr_d;
            score       <= score_d;
            busy        <= busy_d;
            update_done <= done_d;
            overrun     <= overrun_d;
            song_done   <= song_done_d;
            pos_q       <= pos_d;
            notes_q     <= notes_d;
        end
    end

    // Flatten slot registers onto the packed ports.
    for (genvar g = 0; g < NUM_BEATS; g++) begin : g_pack
        assign beat_pos[g*POS_W +: POS_W] = pos_q[g];
        assign beat_notes[g*4 +: 4]       = notes_q[g];
    end

endmodule
